// File: rtl/wb_initiator_if.sv
// rtl/wb_initiator_if.sv - Wishbone classic bus signal bundle with master/slave views
interface wb_bus;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (
    output addr, wdata, sel, we, cyc, stb,
    input  ack, err, rdata
  );

  modport slave (
    input  addr, wdata, sel, we, cyc, stb,
    output ack, err, rdata
  );
endinterface

// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - single-outstanding Wishbone classic initiator with timeout
module wb_initiator #(
  parameter int TimeoutCycles = 255,
  parameter bit CheckAlign    = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset_in,
  wb_bus.master       bus_master,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [3:0]  req_sel,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  localparam logic [15:0] LastCount = 16'(TimeoutCycles - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        load;
  logic        finish;
  logic        fin_err;
  logic [31:0] fin_rdata;
  logic        misaligned;

  assign misaligned = CheckAlign && (req_addr[1:0] != 2'b00);

  // cyc/stb decode straight from the state register so reset drops them without a clock
  assign bus_master.cyc   = (state_q == ACTIVE);
  assign bus_master.stb   = (state_q == ACTIVE);
  assign bus_master.addr  = addr_q;
  assign bus_master.wdata = wdata_q;
  assign bus_master.sel   = sel_q;
  assign bus_master.we    = we_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    load       = 1'b0;
    finish     = 1'b0;
    fin_err    = 1'b0;
    fin_rdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_d = '0;
          if (misaligned) begin
            state_d = RESP;
            finish  = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_d = ACTIVE;
            load    = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // err outranks ack; ack in the final allowed cycle still beats the timeout
        if (bus_master.err) begin
          state_d = RESP;
          finish  = 1'b1;
          fin_err = 1'b1;
        end else if (bus_master.ack) begin
          state_d   = RESP;
          finish    = 1'b1;
          fin_rdata = we_q ? 32'h0 : bus_master.rdata;
        end else if (cnt_q == LastCount) begin
          state_d = RESP;
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        sel_q   <= req_sel;
        we_q    <= req_we;
      end else if (finish) begin
        sel_q <= '0;
        we_q  <= 1'b0;
      end
      if (finish) begin
        resp_rdata <= fin_rdata;
        resp_err   <= fin_err;
      end
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - randomized self-checking bench for wb_initiator
module tb_wb_initiator;

  localparam int Timeout = 8;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  wb_bus bus ();

  wb_initiator #(.TimeoutCycles(Timeout), .CheckAlign(1'b1)) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .bus_master (bus.master),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_sel    (req_sel),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc_count = 0;

  logic [31:0] mem [16];

  logic        chk_en = 1'b0;
  logic        exp_cyc, exp_req_ready, exp_resp_valid, exp_we, exp_err, chk_wesel0;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the expected protocol view set up by the driver
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("cyc", {31'b0, bus.cyc}, {31'b0, exp_cyc});
      chk("stb", {31'b0, bus.stb}, {31'b0, exp_cyc});
      chk("req_ready", {31'b0, req_ready}, {31'b0, exp_req_ready});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_resp_valid});
      if (exp_cyc) begin
        chk("addr", bus.addr, exp_addr);
        chk("wdata", bus.wdata, exp_wdata);
        chk("we", {31'b0, bus.we}, {31'b0, exp_we});
        chk("sel", {28'b0, bus.sel}, {28'b0, exp_sel});
      end
      if (exp_resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
      end
      if (chk_wesel0) begin
        chk("we_idle", {31'b0, bus.we}, 32'h0);
        chk("sel_idle", {28'b0, bus.sel}, 32'h0);
      end
      if (bus.cyc) cyc_count++;
    end
  end

  // mode: 0 ack, 1 err, 2 ack+err, 3 silent; w = index of the bus cycle the slave answers in
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [3:0] sel, input int mode, input int w, input int hold,
                         output logic [31:0] got_rdata, output logic got_err);
    int          c;
    logic        mis;
    logic [3:0]  idx;
    logic [31:0] e_rd;
    logic        e_err;
    idx  = a[5:2];
    mis  = (a[1:0] != 2'b00);
    e_rd = 32'h0;
    if (mis) begin
      c = 0; e_err = 1'b1;
    end else if (mode == 3 || w >= Timeout) begin
      c = Timeout; e_err = 1'b1;
    end else begin
      c = w + 1;
      e_err = (mode != 0);
      if (mode == 0 && !we) e_rd = mem[idx];
    end

    chk_wesel0 = 1'b0;
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_we = we; req_sel = sel;
    bus.ack = 1'($urandom); bus.err = 1'($urandom); resp_ready = 1'($urandom);
    exp_req_ready = 1'b1; exp_cyc = 1'b0; exp_resp_valid = 1'b0;
    @(posedge clk_in); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
    req_sel = 4'($urandom); resp_ready = 1'b0;
    exp_req_ready = 1'b0;
    exp_addr = a; exp_wdata = wd; exp_we = we; exp_sel = sel;
    for (int i = 0; i < c; i++) begin
      exp_cyc   = 1'b1;
      bus.ack   = (mode == 0 || mode == 2) && (i == w);
      bus.err   = (mode == 1 || mode == 2) && (i == w);
      bus.rdata = we ? $urandom : mem[idx];
      @(posedge clk_in); #1;
    end
    bus.ack = 1'b0; bus.err = 1'b0;
    if (!mis && mode == 0 && w < Timeout && we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
    end

    exp_cyc = 1'b0; exp_resp_valid = 1'b1; exp_rdata = e_rd; exp_err = e_err;
    chk_wesel0 = (c > 0);
    for (int j = 0; j < hold; j++) begin
      resp_ready = 1'b0;
      req_valid = 1'($urandom); req_addr = {$urandom, 2'b00}; req_we = 1'($urandom);
      bus.ack = 1'($urandom); bus.err = 1'($urandom); bus.rdata = $urandom;
      @(posedge clk_in); #1;
    end
    resp_ready = 1'b1;
    req_valid = 1'($urandom); req_addr = 32'h4000;
    got_rdata = resp_rdata; got_err = resp_err;
    @(posedge clk_in); #1;
    resp_ready = 1'b0; req_valid = 1'b0; bus.ack = 1'b0; bus.err = 1'b0;
    exp_resp_valid = 1'b0; exp_req_ready = 1'b1;
  endtask

  task automatic reset_mid_active();
    chk_wesel0 = 1'b0;
    bus.ack = 1'b0; bus.err = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4008; req_we = 1'b0; req_sel = 4'hF; req_wdata = 32'h0;
    exp_req_ready = 1'b1; exp_cyc = 1'b0; exp_resp_valid = 1'b0;
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    exp_req_ready = 1'b0; exp_cyc = 1'b1;
    exp_addr = 32'h4008; exp_wdata = 32'h0; exp_we = 1'b0; exp_sel = 4'hF;
    repeat (2) begin @(posedge clk_in); #1; end
    chk_en = 1'b0;
    #2 reset_in = 1'b0;
    #1;
    chk("rst_async_cyc", {31'b0, bus.cyc}, 32'h0);
    chk("rst_async_stb", {31'b0, bus.stb}, 32'h0);
    chk("rst_async_resp_valid", {31'b0, resp_valid}, 32'h0);
    #2 reset_in = 1'b1;
    exp_cyc = 1'b0; exp_req_ready = 1'b1; exp_resp_valid = 1'b0; chk_wesel0 = 1'b1;
    chk_en = 1'b1;
    repeat (4) begin @(posedge clk_in); #1; end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          c0;
    int          mode, w, hold;
    logic [31:0] a;

    for (int k = 0; k < 16; k++) mem[k] = 32'h0;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; req_sel = '0;
    resp_ready = 1'b0;
    bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = '0;
    exp_cyc = 1'b0; exp_req_ready = 1'b1; exp_resp_valid = 1'b0; chk_wesel0 = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_we = 1'b0; exp_sel = '0; exp_rdata = '0; exp_err = 1'b0;

    #12;
    chk("reset_cyc", {31'b0, bus.cyc}, 32'h0);
    chk("reset_stb", {31'b0, bus.stb}, 32'h0);
    chk("reset_we", {31'b0, bus.we}, 32'h0);
    chk("reset_sel", {28'b0, bus.sel}, 32'h0);
    chk("reset_addr", bus.addr, 32'h0);
    chk("reset_wdata", bus.wdata, 32'h0);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_resp_err", {31'b0, resp_err}, 32'h0);
    chk("reset_req_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk_in); #1;
    reset_in = 1'b1;
    chk_en = 1'b1;
    @(posedge clk_in); #1;

    c0 = cyc_count;
    run_txn(32'h4000, 32'h5, 1'b1, 4'h1, 0, 0, 0, rd, er);
    chk("wr_cyc_cycles", cyc_count - c0, 32'd1);
    chk("wr_err", {31'b0, er}, 32'h0);
    chk("wr_rdata", rd, 32'h0);
    chk("led_model", mem[0], 32'h5);

    run_txn(32'h4000, 32'h0, 1'b0, 4'hF, 0, 0, 0, rd, er);
    chk("rd_rdata", rd, 32'h5);
    chk("rd_err", {31'b0, er}, 32'h0);

    run_txn(32'h4004, 32'h0, 1'b0, 4'hF, 2, 2, 1, rd, er);
    chk("ackerr_err", {31'b0, er}, 32'h1);
    chk("ackerr_rdata", rd, 32'h0);

    c0 = cyc_count;
    run_txn(32'h4030, 32'h0, 1'b0, 4'hF, 3, 0, 0, rd, er);
    chk("timeout_cycles", cyc_count - c0, 32'd8);
    chk("timeout_err", {31'b0, er}, 32'h1);

    c0 = cyc_count;
    run_txn(32'h4000, 32'h0, 1'b0, 4'hF, 0, 7, 0, rd, er);
    chk("late_ack_cycles", cyc_count - c0, 32'd8);
    chk("late_ack_err", {31'b0, er}, 32'h0);
    chk("late_ack_rdata", rd, 32'h5);

    c0 = cyc_count;
    run_txn(32'h4002, 32'h0, 1'b0, 4'hF, 0, 0, 0, rd, er);
    chk("misalign_cycles", cyc_count - c0, 32'd0);
    chk("misalign_err", {31'b0, er}, 32'h1);

    reset_mid_active();
    run_txn(32'h4000, 32'h0, 1'b0, 4'hF, 0, 1, 0, rd, er);
    chk("post_reset_rdata", rd, 32'h5);

    run_txn(32'h4010, 32'hA5A5_0F0F, 1'b1, 4'hF, 0, 3, 5, rd, er);
    chk("hold_err", {31'b0, er}, 32'h0);

    for (int t = 0; t < 160; t++) begin
      a = 32'h4000 + 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      mode = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) mode = 0;
      w    = $urandom_range(0, 9);
      hold = $urandom_range(0, 3);
      run_txn(a, $urandom, 1'($urandom), 4'($urandom), mode, w, hold, rd, er);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
